division: RTL and testbench

DIVISION -- requirements
Module: division

---
 rtl/division_pkg.sv | 14 +
 rtl/division_step.sv | 32 +++
 rtl/division.sv | 144 ++++++++++++++
 tb/tb_division.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/division_pkg.sv
// Shared definitions for the arithmetic blocks (divider and multiplier).
// Holds the one-hot FSM state encoding and the default operand width.
package division_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // One-hot controller states.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CALC = 3'b010,
    DONE = 3'b100
  } state_t;

endpackage

// File: rtl/division_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   i_rem     - current partial remainder (WIDTH+1 bits)
//   i_bit     - next dividend bit to shift in (MSB first)
//   i_divisor - divisor
//   o_rem     - partial remainder after this iteration
//   o_qbit    - quotient bit produced by this iteration
module division_step
  import division_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_trial;

  // The remainder is always below the divisor, so its top bit is zero and the
  // shifted value fits in WIDTH+1 bits; one extra bit holds the borrow.
  assign w_shifted = {i_rem, i_bit};
  assign w_trial   = w_shifted - {2'b00, i_divisor};

  // A clear borrow bit means the trial subtraction did not go negative.
  assign o_qbit = ~w_trial[WIDTH+1];
  assign o_rem  = o_qbit ? w_trial[WIDTH:0] : w_shifted[WIDTH:0];

endmodule

// File: rtl/division.sv
// Unsigned sequential divider: restoring shift-subtract, one quotient bit per
// clock, MSB first.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset
//   start    - operation request (level); a new operation needs low then high
//   ready    - high when idle or result valid, low while computing
//   A, B     - dividend and divisor, captured on the start-sampling edge
//   Q, R     - registered quotient and remainder
//   div_zero - high when the last operation had B == 0
// Divide-by-zero returns Q = all ones, R = A in a single cycle.
module division
  import division_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t r_state;
  state_t w_next_state;

  // Working registers.
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_count;

  // Result registers.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_div_zero;
  logic             r_ready;

  logic [WIDTH:0]   w_rem;
  logic             w_qbit;
  logic             w_accept;
  logic             w_b_zero;
  logic             w_count_zero;
  logic             w_finish;
  logic             w_iterate;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_b_zero     = (B == '0);
  assign w_count_zero = (r_count == '0);
  // The edge after the last iteration publishes the result, which gives the
  // WIDTH+1 edge latency from the start-sampling edge.
  assign w_finish     = (r_state == CALC) && w_count_zero;
  assign w_iterate    = (r_state == CALC) && !w_count_zero;

  division_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_dividend[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_rem),
    .o_qbit   (w_qbit)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = w_b_zero ? DONE : CALC;
      CALC: if (w_count_zero) w_next_state = DONE;
      DONE: if (!start) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: working registers are reset too, so an aborted operation leaves no
  // partial state behind to leak into a later result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_count    <= '0;
    end else if (w_accept) begin
      r_dividend <= A;
      r_divisor  <= B;
      r_quot     <= '0;
      r_rem      <= '0;
      r_count    <= CW'(WIDTH);
    end else if (w_iterate) begin
      r_rem      <= w_rem;
      r_quot     <= {r_quot[WIDTH-2:0], w_qbit};
      r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
      r_count    <= r_count - CW'(1);
    end
  end

  // Results only move at completion, so the previous result stays visible
  // throughout CALC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q        <= '0;
      r_r        <= '0;
      r_div_zero <= 1'b0;
      r_ready    <= 1'b1;
    end else if (w_accept && w_b_zero) begin
      r_q        <= '1;
      r_r        <= A;
      r_div_zero <= 1'b1;
      r_ready    <= 1'b1;
    end else if (w_accept) begin
      r_ready    <= 1'b0;
    end else if (w_finish) begin
      r_q        <= r_quot;
      r_r        <= r_rem[WIDTH-1:0];
      r_div_zero <= 1'b0;
      r_ready    <= 1'b1;
    end
  end

  assign ready    = r_ready;
  assign Q        = r_q;
  assign R        = r_r;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_division.sv
// Scoreboard bench for the divider: the driver pushes the expected result of
// each operation (from plain / and %) and a monitor checks busy behaviour,
// latency and the final result independently.
module tb_division;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_zero;

  always #5 clock = ~clock;

  division #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ready   (ready),
    .A       (A),
    .B       (B),
    .Q       (Q),
    .R       (R),
    .div_zero(div_zero)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         sb[$];
  logic [W-1:0] prev_q   = '0;
  logic [W-1:0] prev_r   = '0;
  logic         prev_dz  = 1'b0;
  bit           mon_busy = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W + 1;
    end
    return e;
  endfunction

  // Issue one operation. Start stays high for 'hold' edges counting the
  // sampling edge; otherwise start and A/B are scrambled while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    logic stable;
    e = model(a, b);
    @(negedge clock); A = a; B = b; start = 1'b1;
    @(posedge clock); #1;
    sb.push_back(e);
    for (int i = 1; i <= e.lat; i++) begin
      @(negedge clock);
      A = $urandom; B = $urandom;
      start = (i < hold) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clock);
    end
    if (hold > e.lat) begin
      stable = 1'b1;
      for (int i = e.lat + 1; i < hold; i++) begin
        @(negedge clock); start = 1'b1; A = $urandom; B = $urandom;
        @(posedge clock); #1;
        if (ready !== 1'b1 || Q !== e.q || R !== e.r || div_zero !== e.dz) stable = 1'b0;
      end
      check_bit("done_hold_stable", stable, 1'b1);
    end
    @(negedge clock); start = 1'b0;
    @(posedge clock);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (mon_busy || sb.size() != 0); i++) @(posedge clock);
    check_bit("scoreboard_drained", mon_busy || sb.size() != 0, 1'b0);
  endtask

  // Monitor: follows each operation edge by edge from its sampling edge.
  initial begin
    exp_t e;
    logic busy_ok;
    forever begin
      while (sb.size() == 0) @(negedge clock);
      mon_busy = 1'b1;
      e = sb.pop_front();
      busy_ok = 1'b1;
      for (int k = 1; k < e.lat; k++) begin
        @(posedge clock); #1;
        if (ready !== 1'b0 || Q !== prev_q || R !== prev_r || div_zero !== prev_dz) busy_ok = 1'b0;
      end
      if (e.lat > 1) check_bit("busy_low_and_result_held", busy_ok, 1'b1);
      @(posedge clock); #1;
      check_bit("ready_at_latency", ready, 1'b1);
      check("quotient", Q, e.q);
      check("remainder", R, e.r);
      check_bit("div_zero", div_zero, e.dz);
      prev_q = e.q; prev_r = e.r; prev_dz = e.dz;
      mon_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset = 1'b0; start = 1'b0; A = '0; B = '0;
    #12;
    check_bit("reset_ready", ready, 1'b1);
    check("reset_q", Q, '0);
    check("reset_r", R, '0);
    check_bit("reset_div_zero", div_zero, 1'b0);
    @(negedge clock); reset = 1'b1;

    do_op(32'd100, 32'd7, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(32'd5, 32'd0, 0);
    do_op(32'd3, 32'd10, 0);
    do_op(32'd10, 32'd10, 0);
    wait_idle();

    // Abort an operation at its tenth CALC edge.
    @(negedge clock); A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (10) @(posedge clock);
    #2; reset = 1'b0;
    #1;
    check_bit("abort_ready", ready, 1'b1);
    check("abort_q", Q, '0);
    check("abort_r", R, '0);
    check_bit("abort_div_zero", div_zero, 1'b0);
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    #1; reset = 1'b1;
    do_op(32'd81, 32'd9, 0);

    // Start held high for 100 cycles must yield exactly one operation.
    do_op(32'd1234567, 32'd89, 100);
    do_op(32'd0, 32'd5, 0);

    repeat (40) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        3: b = a;
        default: begin
          a = W'($urandom_range(0, 20));
          b = W'($urandom_range(21, 1000));
        end
      endcase
      do_op(a, b, 0);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
